// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer
// Holds one WIDTH x HEIGHT frame in an internal RAM and replays it in raster
// order as a valid/ready pixel stream with row and frame markers. It feeds the
// 5x5 sliding-window line buffers. An optional idle gap after each row (except
// the last) gives the downstream line buffers time to rotate.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   wr_en      frame RAM write strobe (ignored while busy)
//   wr_addr    write address = row*WIDTH+col
//   wr_data    pixel to store
//   start      begin streaming the stored frame (sampled in IDLE only)
//   ready      downstream accepts pixel this cycle
//   pixel_out  current pixel
//   valid_out  pixel_out valid
//   sol/eol    pixel is column 0 / column WIDTH-1
//   sof/eof    pixel is first / last pixel of the frame
//   busy       high from accepted start until done
//   done       one-cycle pulse after the last pixel is transferred
module frame_pixel_streamer #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int PIX_W  = 8,
  parameter int GAP    = 0,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  input  logic              ready,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              valid_out,
  output logic              sol,
  output logic              eol,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GW    = (GAP    > 1) ? $clog2(GAP)    : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREFETCH = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [PIX_W-1:0]  mem [DEPTH];
  logic [2:0]        state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr;
  logic [GW-1:0]     gap_cnt;
  logic              last_col;
  logic              last_row;
  logic              xfer;
  logic              load_pix;
  logic [ADDR_W-1:0] load_addr;

  assign last_col = (col == CW'(WIDTH - 1));
  assign last_row = (row == RW'(HEIGHT - 1));
  assign xfer     = (state == S_STREAM) && valid_out && ready;
  assign busy     = (state == S_PREFETCH) || (state == S_STREAM) || (state == S_GAP);
  assign done     = (state == S_DONE);

  // Markers describe the presented pixel, so they come from the registered
  // col/row and are only meaningful while valid_out is high.
  assign sol = valid_out && (col == '0);
  assign eol = valid_out && last_col;
  assign sof = valid_out && (col == '0) && (row == '0);
  assign eof = valid_out && last_col && last_row;

  // The pixel_out register is the RAM read register. It is only reloaded when
  // a new pixel must be presented, which keeps it stable during back-pressure.
  // On a mid-row transfer it reads addr+1 so the next pixel appears the very
  // next cycle. After a row gap, addr already points at the next row's first
  // pixel.
  always_comb begin
    load_pix  = 1'b0;
    load_addr = addr;
    case (state)
      S_PREFETCH: load_pix = 1'b1;
      S_STREAM: begin
        if (xfer && !(last_col && (last_row || GAP > 0))) begin
          load_pix  = 1'b1;
          load_addr = addr + ADDR_W'(1);
        end
      end
      S_GAP:   load_pix = (gap_cnt == '0);
      default: load_pix = 1'b0;
    endcase
  end

  // Frame RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out <= '0;
    end else if (load_pix) begin
      pixel_out <= mem[load_addr];
    end
  end

  // Sequencing of the stream. The counters track the presented pixel and only
  // move on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      gap_cnt   <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_PREFETCH;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
          end
        end
        S_PREFETCH: begin
          valid_out <= 1'b1;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            if (last_col && last_row) begin
              valid_out <= 1'b0;
              state     <= S_DONE;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (last_col) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
              if (last_col && GAP > 0) begin
                valid_out <= 1'b0;
                gap_cnt   <= GW'(GAP - 1);
                state     <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            valid_out <= 1'b1;
            state     <= S_STREAM;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer
// Directed bench for frame_pixel_streamer. The instance dut uses GAP=0 and the
// instance dut_gap uses GAP=3. Both share the reset and the RAM write port.
// The RAM holds pixel = addr[7:0], so the expected value of stream pixel idx is
// idx[7:0], except where a test rewrites address 5.
module tb_frame_pixel_streamer;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, ready, start_g, ready_g;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] pixel_out, pixel_g;
  logic       valid_out, sol, eol, sof, eof, busy, done;
  logic       valid_g, sol_g, eol_g, sof_g, eof_g, busy_g, done_g;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  frame_pixel_streamer #(.WIDTH(32), .HEIGHT(32), .PIX_W(8), .GAP(0), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .ready(ready), .pixel_out(pixel_out), .valid_out(valid_out),
    .sol(sol), .eol(eol), .sof(sof), .eof(eof), .busy(busy), .done(done));

  frame_pixel_streamer #(.WIDTH(32), .HEIGHT(32), .PIX_W(8), .GAP(3), .ADDR_W(10)) dut_gap (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_g), .ready(ready_g), .pixel_out(pixel_g), .valid_out(valid_g),
    .sol(sol_g), .eol(eol_g), .sof(sof_g), .eof(eof_g), .busy(busy_g), .done(done_g));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram();
    for (int a = 0; a < 1024; a++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(a);
      wr_data = 8'(a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Streams one frame from dut and collects statistics. It does no checking.
  // The counter cyc counts edges after the one that sampled start.
  task automatic run_frame(input bit rand_ready, input logic [7:0] pix5,
                           input int wr_at, input int start_at,
                           output int lat, output int count, output int data_err,
                           output int mark_err, output int stall_err, output int busy_err,
                           output int span, output int done_gap, output int post_busy,
                           output int timeout);
    int cyc, first, eof_c, done_c, idx, c, r;
    bit stalled;
    logic [7:0] hp, ep;
    logic [3:0] hm, em;
    first = -1; eof_c = -1; done_c = -1; idx = 0; stalled = 1'b0;
    data_err = 0; mark_err = 0; stall_err = 0; busy_err = 0;
    hp = '0; hm = '0;
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done_c < 0 && cyc < 6000) begin
      wr_en = (cyc == wr_at);
      wr_addr = 10'd5;
      wr_data = 8'hAA;
      start = (cyc == start_at);
      if (done) begin
        done_c = cyc;
        if (busy) busy_err++;
        if (valid_out || {sol, eol, sof, eof} !== 4'b0) mark_err++;
      end else begin
        if (!busy) busy_err++;
        if (valid_out) begin
          if (first < 0) first = cyc;
          c  = idx % 32;
          r  = idx / 32;
          ep = (idx == 5) ? pix5 : 8'(idx);
          em = {c == 0, c == 31, idx == 0, idx == 1023};
          if (pixel_out !== ep) data_err++;
          if ({sol, eol, sof, eof} !== em || r > 31) mark_err++;
          if (stalled && (pixel_out !== hp || {sol, eol, sof, eof} !== hm)) stall_err++;
          ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (ready) begin
            if (idx == 1023) eof_c = cyc;
            idx++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            hp = pixel_out;
            hm = {sol, eol, sof, eof};
          end
        end else begin
          if ({sol, eol, sof, eof} !== 4'b0) mark_err++;
          if (stalled) stall_err++;
          ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      if (done_c < 0) begin
        tick();
        cyc++;
      end
    end
    wr_en = 1'b0; start = 1'b0; ready = 1'b0;
    timeout  = (done_c < 0) ? 1 : 0;
    lat      = first;
    count    = idx;
    span     = eof_c - first;
    done_gap = done_c - eof_c;
    tick();
    post_busy = (busy || done) ? 1 : 0;
    tick();
    if (busy) post_busy = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({pixel_out, valid_out, sol, eol, sof, eof, busy, done} !== 15'b0)
      $display("[TB] FAIL reset_outputs: got %h expected 0", {pixel_out, valid_out, sol, eol, sof, eof, busy, done});
    else passed++;
    checks++;
    if ({pixel_g, valid_g, sol_g, eol_g, sof_g, eof_g, busy_g, done_g} !== 15'b0)
      $display("[TB] FAIL reset_outputs_gap: got %h expected 0", {pixel_g, valid_g, sol_g, eol_g, sof_g, eof_g, busy_g, done_g});
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int lat, cnt, de, me, se, be, span, dg, pb, to;
    run_frame(1'b0, 8'd5, -1, -1, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++; if (to !== 0) $display("[TB] FAIL stream_timeout: got %0d expected 0", to); else passed++;
    checks++; if (lat !== 2) $display("[TB] FAIL stream_latency: got %0d expected 2", lat); else passed++;
    checks++; if (cnt !== 1024) $display("[TB] FAIL stream_count: got %0d expected 1024", cnt); else passed++;
    checks++; if (de !== 0) $display("[TB] FAIL stream_data: got %0d bad pixels expected 0", de); else passed++;
    checks++; if (me !== 0) $display("[TB] FAIL stream_markers: got %0d bad cycles expected 0", me); else passed++;
    checks++; if (span !== 1023) $display("[TB] FAIL stream_no_bubbles: got span %0d expected 1023", span); else passed++;
    checks++; if (dg !== 1) $display("[TB] FAIL stream_done_pulse: got offset %0d expected 1", dg); else passed++;
    checks++; if (be !== 0) $display("[TB] FAIL stream_busy: got %0d bad cycles expected 0", be); else passed++;
    checks++; if (pb !== 0) $display("[TB] FAIL stream_idle_after: got %0d expected 0", pb); else passed++;
  endtask

  task automatic test_backpressure();
    int lat, cnt, de, me, se, be, span, dg, pb, to;
    run_frame(1'b1, 8'd5, -1, -1, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++; if (to !== 0) $display("[TB] FAIL bp_timeout: got %0d expected 0", to); else passed++;
    checks++; if (cnt !== 1024) $display("[TB] FAIL bp_count: got %0d expected 1024", cnt); else passed++;
    checks++; if (de !== 0) $display("[TB] FAIL bp_data: got %0d bad pixels expected 0", de); else passed++;
    checks++; if (me !== 0) $display("[TB] FAIL bp_markers: got %0d bad cycles expected 0", me); else passed++;
    checks++; if (se !== 0) $display("[TB] FAIL bp_stall_stable: got %0d unstable cycles expected 0", se); else passed++;
    checks++; if (dg !== 1) $display("[TB] FAIL bp_done_pulse: got offset %0d expected 1", dg); else passed++;
  endtask

  task automatic test_gap();
    int cyc, idx, first, eof_c, done_c, gap_len, ngaps, bad_gap, de, c;
    first = -1; eof_c = -1; done_c = -1; idx = 0;
    gap_len = 0; ngaps = 0; bad_gap = 0; de = 0;
    ready_g = 1'b1;
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    cyc = 1;
    while (done_c < 0 && cyc < 6000) begin
      if (done_g) begin
        done_c = cyc;
      end else if (valid_g) begin
        if (first < 0) first = cyc;
        if (gap_len > 0) begin
          ngaps++;
          if (gap_len != 3 || idx % 32 != 0) bad_gap++;
          gap_len = 0;
        end
        c = idx % 32;
        if (pixel_g !== 8'(idx)) de++;
        if ({sol_g, eol_g, sof_g, eof_g} !== {c == 0, c == 31, idx == 0, idx == 1023}) de++;
        if (idx == 1023) eof_c = cyc;
        idx++;
      end else if (idx > 0) begin
        gap_len++;
        if ({sol_g, eol_g, sof_g, eof_g} !== 4'b0) de++;
      end
      if (done_c < 0) begin
        tick();
        cyc++;
      end
    end
    ready_g = 1'b0;
    checks++; if (done_c < 0) $display("[TB] FAIL gap_timeout: got no done expected done"); else passed++;
    checks++; if (ngaps !== 31) $display("[TB] FAIL gap_count: got %0d expected 31", ngaps); else passed++;
    checks++; if (bad_gap !== 0) $display("[TB] FAIL gap_length: got %0d bad gaps expected 0", bad_gap); else passed++;
    checks++; if (eof_c - first !== 1116) $display("[TB] FAIL gap_span: got %0d expected 1116", eof_c - first); else passed++;
    checks++; if (de !== 0) $display("[TB] FAIL gap_data: got %0d bad cycles expected 0", de); else passed++;
    checks++; if (done_c - eof_c !== 1) $display("[TB] FAIL gap_done_pulse: got offset %0d expected 1", done_c - eof_c); else passed++;
    tick();
  endtask

  task automatic test_start_ignored();
    int lat, cnt, de, me, se, be, span, dg, pb, to;
    run_frame(1'b0, 8'd5, -1, 300, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++; if (de !== 0 || cnt !== 1024) $display("[TB] FAIL start_busy_data: got %0d bad of %0d expected 0 of 1024", de, cnt); else passed++;
    checks++; if (span !== 1023) $display("[TB] FAIL start_busy_span: got %0d expected 1023", span); else passed++;
    checks++; if (pb !== 0) $display("[TB] FAIL start_busy_restart: got busy %0d expected 0", pb); else passed++;
  endtask

  task automatic test_write_busy();
    int lat, cnt, de, me, se, be, span, dg, pb, to;
    run_frame(1'b0, 8'd5, 10, -1, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++; if (de !== 0) $display("[TB] FAIL wr_busy_frame: got %0d bad pixels expected 0", de); else passed++;
    run_frame(1'b0, 8'd5, -1, -1, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++; if (de !== 0) $display("[TB] FAIL wr_busy_ignored: got %0d bad pixels expected 0", de); else passed++;
  endtask

  task automatic test_write_idle();
    int lat, cnt, de, me, se, be, span, dg, pb, to;
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    run_frame(1'b0, 8'hAA, -1, -1, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++; if (de !== 0) $display("[TB] FAIL wr_idle_applied: got %0d bad pixels expected 0", de); else passed++;
  endtask

  task automatic test_reset_mid();
    int idx, cyc, bad;
    int lat, cnt, de, me, se, be, span, dg, pb, to;
    idx = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!(valid_out && idx == 500) && cyc < 2000) begin
      if (valid_out) idx++;
      tick();
      cyc++;
    end
    checks++;
    if (!valid_out || pixel_out !== 8'd244)
      $display("[TB] FAIL rst_mid_pixel500: got valid %0d pixel %0d expected valid 1 pixel 244", valid_out, pixel_out);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready = 1'b0;
    checks++;
    if ({pixel_out, valid_out, sol, eol, sof, eof, busy, done} !== 15'b0)
      $display("[TB] FAIL rst_mid_outputs: got %h expected 0", {pixel_out, valid_out, sol, eol, sof, eof, busy, done});
    else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || valid_out || busy) bad++;
    end
    checks++; if (bad !== 0) $display("[TB] FAIL rst_mid_no_done: got %0d active cycles expected 0", bad); else passed++;
    run_frame(1'b0, 8'hAA, -1, -1, lat, cnt, de, me, se, be, span, dg, pb, to);
    checks++;
    if (de !== 0 || lat !== 2 || cnt !== 1024)
      $display("[TB] FAIL rst_mid_restart: got %0d bad latency %0d count %0d expected 0 2 1024", de, lat, cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, eof_c, done_c, sof2;
    logic [7:0] pix2;
    eof_c = -1; done_c = -1; sof2 = -1; pix2 = 8'hFF;
    ready = 1'b1;
    start = 1'b1;
    tick();
    cyc = 1;
    while (sof2 < 0 && cyc < 5000) begin
      if (valid_out && eof && eof_c < 0) eof_c = cyc;
      if (done && done_c < 0) done_c = cyc;
      if (valid_out && sof && eof_c >= 0) begin
        sof2 = cyc;
        pix2 = pixel_out;
      end else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    checks++; if (sof2 < 0) $display("[TB] FAIL b2b_second_sof: got none expected sof"); else passed++;
    checks++; if (done_c - eof_c !== 1) $display("[TB] FAIL b2b_done: got offset %0d expected 1", done_c - eof_c); else passed++;
    checks++; if (sof2 - eof_c !== 4) $display("[TB] FAIL b2b_sof_offset: got %0d expected 4", sof2 - eof_c); else passed++;
    checks++; if (pix2 !== 8'h00) $display("[TB] FAIL b2b_first_pixel: got %0d expected 0", pix2); else passed++;
    cyc = 0;
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
    checks++; if (!done) $display("[TB] FAIL b2b_second_done: got no done expected done"); else passed++;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle: got busy %0d expected 0", busy); else passed++;
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; ready = 1'b0; start_g = 1'b0; ready_g = 1'b0;
    test_reset();
    load_ram();
    test_stream();
    test_backpressure();
    test_gap();
    test_start_ignored();
    test_write_busy();
    test_write_idle();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
- Raster-order pixel source that feeds the 5x5 sliding-window line buffers.
- Holds one WIDTH x HEIGHT frame in an internal RAM. The RAM is loaded via a simple write port.
- On start, the frame is emitted as a pixel_out/valid_out stream with ready back-pressure and row/frame markers.
- Optional inter-row idle gap lets downstream line buffers rotate without stalling.

Parameters:
WIDTH, 32, pixels per row
HEIGHT, 32, rows per frame
PIX_W, 8, bits per pixel
GAP, 0, idle cycles (valid_out low) inserted after each row's last pixel, except after the final row
ADDR_W, 10, RAM address width; must equal clog2(WIDTH*HEIGHT)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  frame RAM write strobe
wr_addr  in  ADDR_W  write address = row*WIDTH+col
wr_data  in  PIX_W  pixel to store
start  in  1  begin streaming the stored frame (sampled in IDLE only)
ready  in  1  downstream accepts pixel this cycle
pixel_out  out  PIX_W  current pixel
valid_out  out  1  pixel_out valid
sol  out  1  qualifies pixel_out as column 0
eol  out  1  qualifies pixel_out as column WIDTH-1
sof  out  1  qualifies pixel_out as row 0, column 0
eof  out  1  qualifies pixel_out as row HEIGHT-1, column WIDTH-1
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last pixel transferred

Behaviour:
- Reset clears state to IDLE and clears col/row counters and gap counter.
- Reset drives all outputs low: pixel_out=0, valid_out, sol, eol, sof, eof, busy, done.
- RAM contents are NOT cleared by reset.
- Writes:
  - wr_en accepted only when busy=0; ignored while busy.
  - Writes to addresses >= WIDTH*HEIGHT are ignored.
- FSM states: IDLE, PREFETCH, STREAM, GAP, DONE.
  - IDLE: start=1 -> PREFETCH; busy goes high next cycle. Read of address 0 issued.
  - PREFETCH: RAM read data registered into pixel_out; valid_out=1 next cycle, with sof=sol=1 -> STREAM. First valid pixel appears exactly 2 cycles after start is sampled.
  - STREAM: a transfer occurs when valid_out && ready.
    - While valid_out && !ready, pixel_out and all markers are held stable. No counter advances.
    - On a transfer of a non-last pixel, the next pixel is presented the following cycle (zero-bubble). This requires a read-ahead of address+1 or an equivalent skid; full throughput is 1 pixel/cycle with ready held high.
    - On transfer of the eol pixel: if GAP>0 and the row is not the last, go to GAP with valid_out low for exactly GAP cycles, then resume with the sol pixel of the next row.
    - On transfer of the eof pixel: valid_out drops next cycle -> DONE.
  - GAP: counter from GAP-1 down to 0. Markers are low. ready is ignored.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- start while busy is ignored. start held high in IDLE after DONE restarts a new frame.
- Counters:
  - col wraps WIDTH-1 -> 0 and increments row.
  - row HEIGHT-1 plus eol terminates the frame. No wrap into a second frame.
- Markers are combinational from the registered col/row of the presented pixel and are gated by valid_out.
- Reset mid-stream: stream aborts the next cycle with all outputs low. No done pulse.

Test Plan:
- RAM loaded with pixel = addr[7:0]; start, ready=1 always -> valid_out first high 2 cycles after start. 1024 consecutive pixels 0,1,...,255,0,... with no bubbles. sof on pixel 0, eol every 32nd, eof on pixel 1023. done pulse 1 cycle after eof transfer.
- Same frame, ready toggling with a pseudo-random 50% pattern -> sequence identical to the previous test. pixel_out and markers stable on every cycle with valid_out=1 && ready=0.
- GAP=3 -> exactly 3 valid_out-low cycles after each of rows 0..30. No gap after row 31. Total cycles from first pixel to eof = 1023+93.
- wr_en to address 5 with 0xAA while busy -> ignored; pixel 5 of the next frame still has its old value. The same write while idle -> pixel 5 = 0xAA.
- reset asserted at pixel 500 -> next cycle all outputs 0, busy=0, no done. A subsequent start streams from pixel 0 with RAM intact.
- start pulses during streaming -> ignored. start held high -> back-to-back frames with one DONE cycle plus 2 cycles latency between eof and the next sof.
